// File: rtl/fsm_mealy_1010_detector.sv
// Mealy detector for the serial pattern 1-0-1-0, one bit per rising clk edge.
// The detect flag is combinational from the current state and data_in.
module fsm_mealy_1010_detector #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  // if/else rather than ?: so that an unknown data_in falls into the '0' branch
  always_comb begin
    w_next = S0;
    case (r_state)
      S0: begin
        if (data_in) w_next = S1;
        else         w_next = S0;
      end
      S1: begin
        if (data_in) w_next = S1;
        else         w_next = S2;
      end
      S2: begin
        if (data_in) w_next = S3;
        else         w_next = S0;
      end
      S3: begin
        if (data_in)      w_next = S1;
        else if (OVERLAP) w_next = S2;
        else              w_next = S0;
      end
      default: w_next = S0;
    endcase
  end

  // Gated by rst so the flag drops the moment reset is asserted
  assign data_out = (r_state == S3) && !data_in && rst;

endmodule

// File: tb/tb_fsm_mealy_1010_detector.sv
// Bench for fsm_mealy_1010_detector: both OVERLAP settings run side by side on
// one input stream and are checked against a last-four-bits reference model.
module tb_fsm_mealy_1010_detector;

  logic clk;
  logic rst;
  logic data_in;
  logic out_ov;
  logic out_no;

  int   checks;
  int   failures;

  logic exp_q_ov[$];
  logic exp_q_no[$];

  // Reference history: bits seen since reset (and, without overlap, since the last match)
  logic [3:0] h_ov;
  logic [3:0] h_no;
  int         n_ov;
  int         n_no;

  fsm_mealy_1010_detector #(.OVERLAP(1'b1)) u_dut_ov (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (out_ov)
  );

  fsm_mealy_1010_detector #(.OVERLAP(1'b0)) u_dut_no (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (out_no)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    h_ov = 4'b0000;
    h_no = 4'b0000;
    n_ov = 0;
    n_no = 0;
  endtask

  // Drive one bit on the falling edge, push expectations, sample mid-period,
  // then advance the model for the rising edge that consumes the bit.
  task automatic drive_bit(input string tag, input logic b);
    logic e_ov;
    logic e_no;
    @(negedge clk);
    data_in = b;
    e_ov = (n_ov >= 3) && ({h_ov[2:0], b} == 4'b1010);
    e_no = (n_no >= 3) && ({h_no[2:0], b} == 4'b1010);
    exp_q_ov.push_back(e_ov);
    exp_q_no.push_back(e_no);
    #2;
    check_bit({tag, "_ov"}, out_ov, exp_q_ov.pop_front());
    check_bit({tag, "_no"}, out_no, exp_q_no.pop_front());
    h_ov = {h_ov[2:0], b};
    n_ov++;
    if (e_no) begin
      h_no = 4'b0000;
      n_no = 0;
    end else begin
      h_no = {h_no[2:0], b};
      n_no++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst     = 1'b0;
    data_in = 1'b0;
    model_clear();
    #2;
    check_bit("rst_pulse_ov", out_ov, 1'b0);
    check_bit("rst_pulse_no", out_no, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_word(input string tag, input logic [15:0] w, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      drive_bit($sformatf("%s_b%0d", tag, len - i), w[i]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    data_in  = 1'b0;
    model_clear();

    // Reset held ~12 ns with clk running and data_in toggling: flag stays low
    for (int i = 0; i < 4; i++) begin
      #3;
      data_in = i[0];
      check_bit($sformatf("reset_hold_ov_%0d", i), out_ov, 1'b0);
      check_bit($sformatf("reset_hold_no_%0d", i), out_no, 1'b0);
    end
    @(negedge clk);
    data_in = 1'b0;
    rst     = 1'b1;
    #2;
    check_bit("post_release_ov", out_ov, 1'b0);
    check_bit("post_release_no", out_no, 1'b0);

    // Directed stream 1,0,0,1,1,0,1,0,1,0,1
    drive_word("dir", 16'b10011010101, 11);

    // Back-to-back 1,0,1,0,1,0,1,0
    pulse_reset();
    drive_word("b2b", 16'b10101010, 8);

    // Reset mid-pattern: reach S3, present the final '0', then drop rst asynchronously
    pulse_reset();
    drive_word("mid", 16'b101, 3);
    @(negedge clk);
    data_in = 1'b0;
    #1;
    check_bit("mid_pre_rst_ov", out_ov, 1'b1);
    check_bit("mid_pre_rst_no", out_no, 1'b1);
    rst = 1'b0;
    #1;
    check_bit("mid_async_rst_ov", out_ov, 1'b0);
    check_bit("mid_async_rst_no", out_no, 1'b0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    drive_bit("mid_after", 1'b0);
    drive_word("mid_again", 16'b1010, 4);

    // Random runs of 20 and 30 bits with a reset in between
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive_bit($sformatf("rnd1_b%0d", i), 1'($urandom_range(0, 1)));
    end
    pulse_reset();
    for (int i = 0; i < 30; i++) begin
      drive_bit($sformatf("rnd2_b%0d", i), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
